// File: rtl/address_sequencer.sv
// address_sequencer
//
// Address generator for the BIST march controller. Owns the sweep counter and
// walks all 2^ADDR_WIDTH addresses once per sweep, transformed by the selected
// address mode (linear, address-complement, Gray code or 2^i bit-swap) and
// direction. The configuration is latched on an accepted start, so the mode
// inputs may change freely while a sweep is running.
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_n_in   asynchronous active-low reset
//   start_in   begin a sweep (accepted in IDLE or DONE)
//   step_in    advance to the next address (accepted in RUN)
//   abort_in   return to IDLE from any state, no done pulse
//   admd_in    address mode: 0 LIN, 1 AC, 2 GC, 3 2I
//   updwn_in   direction: 0 up, 1 down
//   i_in       bit index for 2I mode
//   addr_out   registered transformed address
//   valid_out  addr_out is a live sweep address
//   last_out   addr_out is the final address of the sweep
//   done_out   one-cycle pulse when the sweep completes
//   busy_out   high while in RUN

module address_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned I_WIDTH    = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  step_in,
    input  logic                  abort_in,
    input  logic [1:0]            admd_in,
    input  logic                  updwn_in,
    input  logic [I_WIDTH-1:0]    i_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic                  done_out,
    output logic                  busy_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] ModeLin = 2'd0;
    localparam logic [1:0] ModeAc  = 2'd1;
    localparam logic [1:0] ModeGc  = 2'd2;
    localparam logic [1:0] Mode2i  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            admd_q, admd_d;
    logic                  updwn_q, updwn_d;
    logic [I_WIDTH-1:0]    i_q, i_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [I_WIDTH-1:0]    i_cap;
    logic                  cnt_full;
    logic                  run_d;

    // An out-of-range bit index degrades 2I mode to an identity swap.
    assign i_cap    = (32'(i_in) >= ADDR_WIDTH) ? '0 : i_in;
    assign cnt_full = (cnt_q == {ADDR_WIDTH{1'b1}});

    function automatic logic [ADDR_WIDTH-1:0] transform(
        input logic [ADDR_WIDTH-1:0] c,
        input logic [1:0]            mode,
        input logic                  d,
        input logic [I_WIDTH-1:0]    idx
    );
        logic [ADDR_WIDTH-1:0] r;
        logic [ADDR_WIDTH-1:0] sw;
        r  = '0;
        sw = c;
        unique case (mode)
            ModeLin: begin
                r = c ^ {ADDR_WIDTH{d}};
            end
            ModeAc: begin
                // Odd counts land on the complement of the preceding even address.
                r[ADDR_WIDTH-1] = c[0] ^ d;
                for (int k = 0; k < int'(ADDR_WIDTH) - 1; k++) begin
                    r[k] = c[k+1] ^ c[0];
                end
            end
            ModeGc: begin
                r[ADDR_WIDTH-1] = c[ADDR_WIDTH-1] ^ d;
                for (int k = 0; k < int'(ADDR_WIDTH) - 1; k++) begin
                    r[k] = c[k] ^ c[k+1];
                end
            end
            Mode2i: begin
                // Loop instead of a variable bit-select keeps the index width free.
                for (int k = 1; k < int'(ADDR_WIDTH); k++) begin
                    if (int'(idx) == k) begin
                        sw[0] = c[k];
                        sw[k] = c[0];
                    end
                end
                r = sw ^ {ADDR_WIDTH{d}};
            end
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        admd_d  = admd_q;
        updwn_d = updwn_q;
        i_d     = i_q;
        done_d  = 1'b0;

        if (abort_in) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_in) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        admd_d  = admd_in;
                        updwn_d = updwn_in;
                        i_d     = i_cap;
                    end
                end
                StRun: begin
                    if (step_in) begin
                        if (cnt_full) begin
                            // Counter parks at all-ones; it never wraps inside a sweep.
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next-state values so they are fully registered.
    always_comb begin
        run_d   = (state_d == StRun);
        valid_d = run_d;
        busy_d  = run_d;
        last_d  = run_d && (cnt_d == {ADDR_WIDTH{1'b1}});
        addr_d  = run_d ? transform(cnt_d, admd_d, updwn_d, i_d) : addr_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            admd_q  <= ModeLin;
            updwn_q <= 1'b0;
            i_q     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            admd_q  <= admd_d;
            updwn_q <= updwn_d;
            i_q     <= i_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign addr_out  = addr_q;
    assign valid_out = valid_q;
    assign last_out  = last_q;
    assign done_out  = done_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer
//
// Directed and randomized bench for address_sequencer. Two instances: an
// 8-bit one for most of the plan and a 6-bit one for the out-of-range i case.
// Expected addresses come from an arithmetic model of each address mode.

module tb_address_sequencer;

    logic       clk_in;
    logic       rst_n_in;
    logic       start8, start6;
    logic       step_in;
    logic       abort_in;
    logic [1:0] admd_in;
    logic       updwn_in;
    logic [2:0] i_in;

    logic [7:0] addr8;
    logic       valid8, last8, done8, busy8;
    logic [5:0] addr6;
    logic       valid6, last6, done6, busy6;

    int n_checks = 0;
    int n_fail   = 0;

    address_sequencer #(.ADDR_WIDTH(8), .I_WIDTH(3)) dut8 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (start8),
        .step_in  (step_in),
        .abort_in (abort_in),
        .admd_in  (admd_in),
        .updwn_in (updwn_in),
        .i_in     (i_in),
        .addr_out (addr8),
        .valid_out(valid8),
        .last_out (last8),
        .done_out (done8),
        .busy_out (busy8)
    );

    address_sequencer #(.ADDR_WIDTH(6), .I_WIDTH(3)) dut6 (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (start6),
        .step_in  (step_in),
        .abort_in (abort_in),
        .admd_in  (admd_in),
        .updwn_in (updwn_in),
        .i_in     (i_in),
        .addr_out (addr6),
        .valid_out(valid6),
        .last_out (last6),
        .done_out (done6),
        .busy_out (busy6)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed hang, required finish)");
        $fatal(1, "watchdog");
    end

    // Reference transform written from the mode definitions with plain arithmetic.
    function automatic int model_t(int w, int mode, int d, int i, int c);
        int mask;
        int msb;
        int r;
        int b0;
        int bi;
        mask = (1 << w) - 1;
        msb  = 1 << (w - 1);
        case (mode)
            0: r = d ? (c ^ mask) : c;
            1: begin
                r = c >> 1;
                if (c % 2 == 1) r = mask - r;
                if (d != 0) r = r ^ msb;
            end
            2: begin
                r = c ^ (c >> 1);
                if (d != 0) r = r ^ msb;
            end
            default: begin
                r = c;
                if (i != 0) begin
                    b0 = c & 1;
                    bi = (c >> i) & 1;
                    r  = (c & ~(1 | (1 << i))) | bi | (b0 << i);
                end
                if (d != 0) r = r ^ mask;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] o_addr(bit s6);
        return s6 ? 32'(addr6) : 32'(addr8);
    endfunction
    function automatic logic [31:0] o_valid(bit s6);
        return s6 ? 32'(valid6) : 32'(valid8);
    endfunction
    function automatic logic [31:0] o_last(bit s6);
        return s6 ? 32'(last6) : 32'(last8);
    endfunction
    function automatic logic [31:0] o_done(bit s6);
        return s6 ? 32'(done6) : 32'(done8);
    endfunction
    function automatic logic [31:0] o_busy(bit s6);
        return s6 ? 32'(busy6) : 32'(busy8);
    endfunction

    task automatic start_cfg(input bit s6, input logic [1:0] mode, input logic d,
                             input logic [2:0] ii);
        admd_in  = mode;
        updwn_in = d;
        i_in     = ii;
        if (s6) start6 = 1'b1;
        else start8 = 1'b1;
        tick();
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic step_n(input int k);
        step_in = 1'b1;
        for (int j = 0; j < k; j++) tick();
        step_in = 1'b0;
    endtask

    task automatic do_abort();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
    endtask

    // Full randomized sweep; returns with the DUT in the done_out cycle.
    task automatic sweep(input bit s6, input logic [1:0] mode, input logic d,
                         input logic [2:0] ii, input int step_pct);
        int  w, n, c, ie, guard;
        bit  fin, newc;
        bit  seen [256];
        logic [31:0] a;
        w  = s6 ? 6 : 8;
        n  = 1 << w;
        ie = (int'(ii) >= w) ? 0 : int'(ii);
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        start_cfg(s6, mode, d, ii);
        c = 0; fin = 1'b0; newc = 1'b1; guard = 0;
        while (!fin && guard < 8 * n) begin
            guard++;
            a = o_addr(s6);
            check("sweep_valid", o_valid(s6), 1);
            check("sweep_busy", o_busy(s6), 1);
            check("sweep_done_low", o_done(s6), 0);
            check("sweep_addr", a, 32'(model_t(w, mode, d, ie, c)));
            check("sweep_last", o_last(s6), 32'(c == n - 1));
            if (newc) begin
                check("sweep_no_dup", 32'(seen[a[7:0]]), 0);
                seen[a[7:0]] = 1'b1;
                newc = 1'b0;
            end
            // Config and start wiggle mid-run; the latched config must win.
            step_in  = ($urandom_range(99) < step_pct);
            admd_in  = 2'($urandom);
            updwn_in = 1'($urandom);
            i_in     = 3'($urandom);
            if (s6) start6 = 1'($urandom);
            else start8 = 1'($urandom);
            tick();
            if (step_in) begin
                if (c == n - 1) fin = 1'b1;
                else begin
                    c++;
                    newc = 1'b1;
                end
            end
        end
        step_in = 1'b0;
        start6  = 1'b0;
        start8  = 1'b0;
        check("sweep_complete", 32'(fin), 1);
        check("end_done_pulse", o_done(s6), 1);
        check("end_valid", o_valid(s6), 0);
        check("end_busy", o_busy(s6), 0);
        check("end_last", o_last(s6), 0);
        check("end_addr_hold", o_addr(s6), 32'(model_t(w, mode, d, ie, n - 1)));
    endtask

    task automatic after_done(input bit s6, input logic [31:0] exp_addr);
        tick();
        check("done_one_cycle", o_done(s6), 0);
        check("idle_valid", o_valid(s6), 0);
        check("idle_addr_hold", o_addr(s6), exp_addr);
    endtask

    initial begin
        rst_n_in = 1'b1;
        start8 = 1'b0; start6 = 1'b0; step_in = 1'b0; abort_in = 1'b0;
        admd_in = 2'd0; updwn_in = 1'b0; i_in = 3'd0;
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_addr", 32'(addr8), 0);
        check("rst_valid", 32'(valid8), 0);
        check("rst_last", 32'(last8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_busy", 32'(busy8), 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();

        // 1: LIN up, step every cycle
        sweep(1'b0, 2'd0, 1'b0, 3'd0, 100);
        after_done(1'b0, 32'hFF);

        // 2: GC up/down directed heads, then randomized sweeps
        start_cfg(1'b0, 2'd2, 1'b0, 3'd0);
        check("gc_up_0", 32'(addr8), 32'h00);
        step_n(1); check("gc_up_1", 32'(addr8), 32'h01);
        step_n(1); check("gc_up_2", 32'(addr8), 32'h03);
        step_n(1); check("gc_up_3", 32'(addr8), 32'h02);
        do_abort();
        start_cfg(1'b0, 2'd2, 1'b1, 3'd0);
        check("gc_dn_0", 32'(addr8), 32'h80);
        step_n(1); check("gc_dn_1", 32'(addr8), 32'h81);
        step_n(1); check("gc_dn_2", 32'(addr8), 32'h83);
        step_n(1); check("gc_dn_3", 32'(addr8), 32'h82);
        do_abort();
        sweep(1'b0, 2'd2, 1'b0, 3'd0, 70);
        after_done(1'b0, 32'(model_t(8, 2, 0, 0, 255)));
        sweep(1'b0, 2'd2, 1'b1, 3'd0, 60);
        after_done(1'b0, 32'(model_t(8, 2, 1, 0, 255)));

        // 3: AC up, mode input changed to GC after start
        start_cfg(1'b0, 2'd1, 1'b0, 3'd0);
        admd_in = 2'd2;
        check("ac_0", 32'(addr8), 32'h00);
        step_n(1); check("ac_1", 32'(addr8), 32'hFF);
        step_n(1); check("ac_2", 32'(addr8), 32'h01);
        step_n(1); check("ac_3", 32'(addr8), 32'hFE);
        do_abort();
        check("abort_done_low", 32'(done8), 0);
        sweep(1'b0, 2'd1, 1'b1, 3'd0, 75);
        after_done(1'b0, 32'(model_t(8, 1, 1, 0, 255)));

        // 4: 2I with i=3, then W=6 with out-of-range i
        start_cfg(1'b0, 2'd3, 1'b0, 3'd3);
        step_n(1); check("2i_up_c1", 32'(addr8), 32'h08);
        step_n(7); check("2i_up_c8", 32'(addr8), 32'h01);
        step_n(1); check("2i_up_c9", 32'(addr8), 32'h09);
        do_abort();
        start_cfg(1'b0, 2'd3, 1'b1, 3'd3);
        step_n(1); check("2i_dn_c1", 32'(addr8), 32'hF7);
        do_abort();
        sweep(1'b0, 2'd3, 1'b1, 3'd3, 80);
        after_done(1'b0, 32'(model_t(8, 3, 1, 3, 255)));
        start_cfg(1'b1, 2'd3, 1'b0, 3'd7);
        step_n(1); check("w6_i7_c1", 32'(addr6), 32'h01);
        do_abort();
        sweep(1'b1, 2'd3, 1'b0, 3'd7, 80);
        after_done(1'b1, 32'h3F);
        sweep(1'b1, 2'd3, 1'b1, 3'd6, 65);
        after_done(1'b1, 32'(model_t(6, 3, 1, 0, 63)));

        // 5: hold, then abort together with step, then restart
        start_cfg(1'b0, 2'd0, 1'b0, 3'd0);
        step_n(16);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("hold_addr", 32'(addr8), 32'h10);
            check("hold_valid", 32'(valid8), 1);
        end
        step_in  = 1'b1;
        abort_in = 1'b1;
        tick();
        step_in  = 1'b0;
        abort_in = 1'b0;
        check("abort_valid", 32'(valid8), 0);
        check("abort_busy", 32'(busy8), 0);
        check("abort_no_done", 32'(done8), 0);
        check("abort_addr_hold", 32'(addr8), 32'h10);
        tick();
        check("abort_no_done_late", 32'(done8), 0);
        start_cfg(1'b0, 2'd0, 1'b0, 3'd0);
        check("restart_addr", 32'(addr8), 32'h00);
        check("restart_valid", 32'(valid8), 1);

        // 6: asynchronous reset mid-sweep, then back-to-back sweeps
        step_n(5);
        check("pre_rst_addr", 32'(addr8), 32'h05);
        #2 rst_n_in = 1'b0;
        #1;
        check("async_rst_addr", 32'(addr8), 0);
        check("async_rst_valid", 32'(valid8), 0);
        check("async_rst_busy", 32'(busy8), 0);
        check("async_rst_last", 32'(last8), 0);
        check("async_rst_done", 32'(done8), 0);
        #2 rst_n_in = 1'b1;
        tick();
        check("post_rst_idle", 32'(valid8), 0);
        sweep(1'b0, 2'd0, 1'b1, 3'd0, 90);
        start_cfg(1'b0, 2'd2, 1'b0, 3'd0);
        check("b2b_valid", 32'(valid8), 1);
        check("b2b_addr", 32'(addr8), 32'h00);
        check("b2b_done_low", 32'(done8), 0);
        do_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
- Parametrised successor to the combinational BIST address transform.
- Owns the address counter and walks the full 2^ADDR_WIDTH space in the selected address mode: linear, address-complement, Gray code, or 2^i bit-swap.
- Supports up/down direction and a start/step/abort handshake with the march controller.
- Output address is registered; it feeds the memory-under-test address mux.

Parameters:
- ADDR_WIDTH, 8, address/counter width in bits; legal range 2..16.
- I_WIDTH, 3, width of i_in; must satisfy 2^I_WIDTH >= ADDR_WIDTH.

Ports:
- clk_in  input  1  system clock; all state changes on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  begin a sweep; sampled only in IDLE or DONE.
- step_in  input  1  advance to the next address; sampled only in RUN.
- abort_in  input  1  terminate the sweep; sampled in every state.
- admd_in  input  2  address mode: 0 = LIN, 1 = AC, 2 = GC, 3 = 2I.
- updwn_in  input  1  direction: 0 = up, 1 = down.
- i_in  input  I_WIDTH  bit index for 2I mode.
- addr_out  output  ADDR_WIDTH  current transformed address.
- valid_out  output  1  addr_out is a live sweep address.
- last_out  output  1  addr_out is the final address of the sweep.
- done_out  output  1  one-cycle pulse when the sweep completes.
- busy_out  output  1  high while in RUN.

Behaviour:
Reset (rst_n_in low, asynchronous):
- state = IDLE, cnt = 0.
- addr_out = 0, valid_out = 0, last_out = 0, done_out = 0, busy_out = 0.
- Reset asserted mid-sweep forces these values immediately, with no clock needed.

Configuration latch:
- admd_in, updwn_in and i_in are captured into config registers on an accepted start.
- Input changes during RUN have no effect.
- If i_in >= ADDR_WIDTH, the captured i is 0.

States:
- IDLE:
  - start_in = 1 -> RUN, cnt = 0.
- RUN:
  - step_in = 1 and cnt != all-ones -> cnt = cnt + 1.
  - step_in = 1 and cnt == all-ones -> DONE, done_out = 1 for exactly one cycle.
  - step_in = 0 -> hold; addr_out stable, valid_out stays 1.
  - start_in is ignored in RUN.
- DONE:
  - start_in = 1 -> RUN with cnt = 0 (back-to-back sweeps allowed).
  - Otherwise stay in DONE.
- Any state: abort_in = 1 -> IDLE, cnt = 0, with no done_out pulse.
  - abort_in has priority over start_in and step_in in the same cycle.

Output timing:
- All outputs are registered.
- Cycle after the accepted start: valid_out = 1, addr_out = T(0).
- Cycle after an accepted step: addr_out = T(cnt + 1).
- valid_out and busy_out are 1 exactly while in RUN.
- last_out = 1 while in RUN with cnt == all-ones.
- In DONE and IDLE: valid_out = 0 and addr_out holds its last value.

Transform T(c), with W = ADDR_WIDTH and d = captured updwn:
- LIN: addr = c XOR {W{d}}, i.e. down mode counts from all-ones to 0.
- AC:
  - addr[W-1] = c[0] ^ d.
  - addr[k] = c[k+1] ^ c[0] for k < W-1.
- GC:
  - addr[W-1] = c[W-1] ^ d.
  - addr[k] = c[k] ^ c[k+1] for k < W-1.
- 2I:
  - c' = c with bits 0 and i swapped; i = 0 means identity.
  - addr = c' XOR {W{d}}.

Sweep length and wrap:
- A sweep is exactly 2^W valid addresses in every mode.
- Each mode is a bijection, so every address appears exactly once.
- cnt never wraps inside a sweep.

Test Plan:
1. W=8, LIN up, start then step every cycle -> addr_out 0x00, 0x01 … 0xFF on 256 valid beats; last_out only with 0xFF; done_out pulse the cycle after the final step; valid_out = 0 after.
2. W=8, GC up -> first four addresses 0x00, 0x01, 0x03, 0x02. Same sweep with GC down -> 0x80, 0x81, 0x83, 0x82. Each run has 256 beats with no duplicate addresses.
3. W=8, AC up -> 0x00, 0xFF, 0x01, 0xFE. Changing admd_in mid-run to GC leaves the sequence unchanged.
4. W=8, 2I with i=3, up -> cnt 1 gives 0x08, cnt 8 gives 0x01, cnt 9 gives 0x09. Same with down -> cnt 1 gives 0xF7. W=6 with i_in=7 -> behaves as LIN.
5. Hold step_in low for 5 cycles at cnt=0x10 -> addr_out stays 0x10 with valid_out = 1. Then abort_in together with step_in -> next cycle valid_out = 0, busy_out = 0, no done_out pulse. A fresh start -> sweep restarts at T(0).
6. Drop rst_n_in mid-sweep between clock edges -> all outputs 0 immediately. Release reset and start -> normal sweep from T(0). Also check a start issued in DONE on the cycle after done_out -> immediate new sweep.
